spi_mode0_master_arbiter: RTL and testbench
===========================================

// Module: spi_mode0_master_arbiter
// PURPOSE
//  SPI master (CPOL=0, CPHA=0, MSB first) shared by NUM_REQ requesters, one slave per requester.
//  Round-robin arbitration grants the bus, drives that requester's chip select and runs one
//  PACK_LENGTH-bit full-duplex transfer. It then returns the received word to the requester.
//  It sits between on-chip clients and the mode-0 SPI slaves on the SCLK/MOSI/MISO bus.
// PARAMETERS
//  PACK_LENGTH  8  bits per transfer
//  NUM_REQ      2  number of requesters and chip selects, >=2
//  CLK_DIV      4  IN_CLK cycles per SCLK half-period, >=2
//  CS_GAP       2  IN_CLK cycles CS stays high after a transfer before the next grant, >=1
// PORTS
//  IN_CLK            in   1                   system clock, all logic on its posedge
//  IN_RESET          in   1                   synchronous reset, active high
//  IN_REQ            in   NUM_REQ             per-requester transfer request, level
//  IN_TX_DATA        in   NUM_REQ*PACK_LENGTH word i at [i*PACK_LENGTH +: PACK_LENGTH]
//  OUT_GRANT         out  NUM_REQ             one-hot owner of the current transfer
//  OUT_DONE          out  NUM_REQ             one-cycle pulse to the owner at end of transfer
//  OUT_RECEIVE_DATA  out  PACK_LENGTH         last received word, valid from the OUT_DONE cycle
//  OUT_BUSY          out  1                   high from grant through the end of the CS_GAP phase
//  SCLK              out  1                   SPI clock, idles low
//  MOSI              out  1                   master data out
//  MISO              in   1                   slave data in
//  CS                out  NUM_REQ             active-low chip selects, one-hot low or all high
// BEHAVIOUR
//  Reset, applied synchronously and also mid-transfer:
//   - On the next edge: CS all 1, SCLK 0, MOSI 0, OUT_GRANT 0, OUT_DONE 0, OUT_BUSY 0, OUT_RECEIVE_DATA 0.
//   - RR pointer returns to 0 and the FSM goes to IDLE.
//   - An aborted transfer produces no OUT_DONE.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  Arbitration, in IDLE:
//   - If any IN_REQ bit is set, pick the first set bit at or after pointer P, modulo NUM_REQ.
//   - On that edge: set OUT_GRANT, capture that requester's IN_TX_DATA into the shift register,
//     drive CS[i]=0, MOSI=MSB, OUT_BUSY=1, P=i+1 mod NUM_REQ.
//  SETUP: hold CLK_DIV cycles with SCLK low, so MOSI is stable before the first rising edge.
//  SHIFT, PACK_LENGTH bit periods, each 2*CLK_DIV cycles:
//   - SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
//   - MISO is sampled into the LSB of the receive shift register on the IN_CLK edge that drives SCLK 0->1.
//   - MOSI advances to the next bit on the edge that drives SCLK 1->0, except after the last bit.
//  HOLD: SCLK low, CS still low, for CLK_DIV cycles.
//   - Then: CS all high, OUT_GRANT cleared, OUT_DONE[i]=1 for exactly 1 cycle,
//     OUT_RECEIVE_DATA updated on that same edge, MOSI=0.
//  GAP: CS_GAP cycles with all CS high, then OUT_BUSY=0 and back to IDLE.
//   - No grant is issued before GAP completes.
//  Latency: grant edge to CS-high/OUT_DONE edge = (2*PACK_LENGTH+2)*CLK_DIV cycles (72 at defaults).
//   - Grant-to-grant for back-to-back requests = that figure + CS_GAP + 1 (75 at defaults).
//  Handshake rules:
//   - IN_TX_DATA only needs to be valid on the grant edge.
//   - Dropping IN_REQ after grant does not abort the transfer.
//   - IN_REQ still high after OUT_DONE counts as a new request and is arbitrated normally.
//  Boundaries:
//   - Requests arriving during SHIFT, HOLD or GAP wait.
//   - Simultaneous requests are resolved purely by P.
//   - A sole requester is served repeatedly.
//   - OUT_RECEIVE_DATA holds its value until the next OUT_DONE.
//   - At most one CS is low at any time; SCLK never toggles while all CS are high.
// TESTING
//  1. Reset, no requests -> CS=2'b11, SCLK=0, OUT_BUSY=0 for 100 cycles.
//  2. REQ[0], TX0=8'hA5, slave returns 8'h3C -> MOSI shows 1010_0101 on rising SCLK;
//     OUT_DONE[0] at 72 cycles after grant; OUT_RECEIVE_DATA=8'h3C.
//  3. REQ=2'b11 held, TX0=8'h01, TX1=8'h80 -> grants alternate 0,1,0,1;
//     grant-to-grant spacing 75 cycles; CS[0] and CS[1] never both low.
//  4. REQ[1] asserted during a REQ[0] transfer -> CS[1] waits until GAP ends; then granted, 8 SCLK pulses.
//  5. IN_RESET for 1 cycle after 3rd SCLK rise -> next edge CS=11, SCLK=0, no OUT_DONE;
//     a fresh REQ[0] then completes normally.
//  6. Sole REQ[1] held high with CLK_DIV=2 -> repeated grants to 1 only;
//     SCLK half-period 2 cycles; DONE every 39 cycles.

Source files
------------

// File: rtl/spi_mode0_master_arbiter.sv
// Mode-0 SPI master shared by NUM_REQ requesters through round-robin arbitration.
// Each grant runs one full-duplex PACK_LENGTH-bit transfer on that requester's chip select.
module spi_mode0_master_arbiter #(
    parameter int PACK_LENGTH = 8,
    parameter int NUM_REQ     = 2,
    parameter int CLK_DIV     = 4,
    parameter int CS_GAP      = 2
) (
    input  logic                           IN_CLK,
    input  logic                           IN_RESET,
    input  logic [NUM_REQ-1:0]             IN_REQ,
    input  logic [NUM_REQ*PACK_LENGTH-1:0] IN_TX_DATA,
    output logic [NUM_REQ-1:0]             OUT_GRANT,
    output logic [NUM_REQ-1:0]             OUT_DONE,
    output logic [PACK_LENGTH-1:0]         OUT_RECEIVE_DATA,
    output logic                           OUT_BUSY,
    output logic                           SCLK,
    output logic                           MOSI,
    input  logic                           MISO,
    output logic [NUM_REQ-1:0]             CS
);

    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW      = (PACK_LENGTH > 1) ? $clog2(PACK_LENGTH) : 1;
    localparam int CNT_MAX = (2 * CLK_DIV > CS_GAP) ? 2 * CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [PW:0]   NUM_REQ_W = (PW + 1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PACK_LENGTH - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [PW-1:0]          rr_ptr;
    logic [PACK_LENGTH-1:0] tx_sr;
    logic [PACK_LENGTH-1:0] rx_sr;

    logic                   pick_valid;
    logic [PW-1:0]          pick_idx;
    logic [PW-1:0]          next_ptr;
    logic [PW:0]            cand;
    logic [NUM_REQ-1:0]     grant_vec;
    logic [PACK_LENGTH-1:0] tx_word;

    // Scan from the farthest offset back to the pointer so the nearest request wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + (PW + 1)'(off);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (IN_REQ[cand[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        next_ptr  = (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
        grant_vec = NUM_REQ'(1) << pick_idx;
        tx_word   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PW'(i)) begin
                tx_word = IN_TX_DATA[i*PACK_LENGTH +: PACK_LENGTH];
            end
        end
    end

    always_ff @(posedge IN_CLK) begin
        OUT_DONE <= '0;
        if (IN_RESET) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            bit_cnt          <= '0;
            rr_ptr           <= '0;
            tx_sr            <= '0;
            rx_sr            <= '0;
            OUT_GRANT        <= '0;
            OUT_RECEIVE_DATA <= '0;
            OUT_BUSY         <= 1'b0;
            SCLK             <= 1'b0;
            MOSI             <= 1'b0;
            CS               <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        OUT_GRANT <= grant_vec;
                        CS        <= ~grant_vec;
                        tx_sr     <= tx_word;
                        MOSI      <= tx_word[PACK_LENGTH-1];
                        OUT_BUSY  <= 1'b1;
                        rr_ptr    <= next_ptr;
                        cnt       <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        SCLK    <= 1'b1;
                        rx_sr   <= {rx_sr[PACK_LENGTH-2:0], MISO};
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Each bit period: rising edge samples MISO, falling edge presents the next MOSI bit.
                ST_SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        SCLK <= 1'b0;
                        if (bit_cnt != BIT_LAST) begin
                            tx_sr <= tx_sr << 1;
                            MOSI  <= tx_sr[PACK_LENGTH-2];
                        end
                    end
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_HOLD;
                        end else begin
                            SCLK    <= 1'b1;
                            rx_sr   <= {rx_sr[PACK_LENGTH-2:0], MISO};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == HALF_LAST) begin
                        cnt              <= '0;
                        CS               <= '1;
                        OUT_GRANT        <= '0;
                        OUT_DONE         <= OUT_GRANT;
                        OUT_RECEIVE_DATA <= rx_sr;
                        MOSI             <= 1'b0;
                        state            <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        OUT_BUSY <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mode0_master_arbiter.sv
// Bench for spi_mode0_master_arbiter: directed transfers against slave models, with a
// scoreboard of expected (owner, received word) pairs checked whenever OUT_DONE fires.
module tb_spi_mode0_master_arbiter;

    logic        IN_CLK = 1'b0;
    logic        IN_RESET;
    logic [1:0]  IN_REQ;
    logic [15:0] IN_TX_DATA;
    logic [1:0]  OUT_GRANT, OUT_DONE, CS;
    logic [7:0]  OUT_RECEIVE_DATA;
    logic        OUT_BUSY, SCLK, MOSI, MISO;

    logic [1:0]  req2;
    logic [15:0] tx2;
    logic [1:0]  grant2, done2, cs2;
    logic [7:0]  rx2;
    logic        busy2, sclk2, mosi2;

    always #5 IN_CLK = ~IN_CLK;

    spi_mode0_master_arbiter dut (
        .IN_CLK(IN_CLK), .IN_RESET(IN_RESET), .IN_REQ(IN_REQ), .IN_TX_DATA(IN_TX_DATA),
        .OUT_GRANT(OUT_GRANT), .OUT_DONE(OUT_DONE), .OUT_RECEIVE_DATA(OUT_RECEIVE_DATA),
        .OUT_BUSY(OUT_BUSY), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
    );

    spi_mode0_master_arbiter #(.CLK_DIV(2)) dut_fast (
        .IN_CLK(IN_CLK), .IN_RESET(IN_RESET), .IN_REQ(req2), .IN_TX_DATA(tx2),
        .OUT_GRANT(grant2), .OUT_DONE(done2), .OUT_RECEIVE_DATA(rx2),
        .OUT_BUSY(busy2), .SCLK(sclk2), .MOSI(mosi2), .MISO(1'b1), .CS(cs2)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    int         exp_idx[$];
    logic [7:0] exp_data[$];
    int         grant_log[$];
    int         done_log[$];
    int         last_grant_cyc = 0;
    int         inv_bad = 0;

    logic [7:0] slave_word[2];
    logic [7:0] exp_tx[2];
    logic [7:0] slv_sr[2];
    logic [7:0] mosi_cap[2];
    int         bit_cnt[2];
    logic       abort_expected = 1'b1;

    logic [1:0] prev_grant = 2'b00;
    logic [1:0] prev_cs = 2'b11;
    logic       prev_sclk = 1'b0;
    logic       prev_sclk2 = 1'b0;
    int         pop_idx;
    logic [7:0] pop_data;

    always @(posedge IN_CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Mode-0 slaves: MSB out while selected, sample MOSI on SCLK rise, shift on SCLK fall.
    assign MISO = !CS[0] ? slv_sr[0][7] : (!CS[1] ? slv_sr[1][7] : 1'b0);

    // Monitor: scoreboard pops on OUT_DONE, slave models, and bus invariants.
    always @(negedge IN_CLK) begin
        if (IN_RESET !== 1'b1) begin
            if (OUT_GRANT != 2'b00 && prev_grant == 2'b00) begin
                last_grant_cyc = cyc;
                grant_log.push_back(cyc);
            end
            if (OUT_DONE != 2'b00) begin
                done_log.push_back(cyc);
                if (exp_idx.size() == 0) begin
                    check("unexpected_done", 32'(OUT_DONE), 0);
                end else begin
                    pop_idx  = exp_idx.pop_front();
                    pop_data = exp_data.pop_front();
                    check("done_owner", 32'(OUT_DONE), 32'(2'b01 << pop_idx));
                    check("rx_data", 32'(OUT_RECEIVE_DATA), 32'(pop_data));
                    check("grant_to_done", cyc - last_grant_cyc, 72);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (prev_cs[i] && !CS[i]) begin
                    slv_sr[i]   = slave_word[i];
                    bit_cnt[i]  = 0;
                    mosi_cap[i] = 8'h00;
                end
                if (!CS[i] && SCLK && !prev_sclk) begin
                    mosi_cap[i] = {mosi_cap[i][6:0], MOSI};
                    bit_cnt[i]++;
                end
                if (!CS[i] && !SCLK && prev_sclk) slv_sr[i] = slv_sr[i] << 1;
                if (!prev_cs[i] && CS[i] && !abort_expected) begin
                    check($sformatf("sclk_pulses_%0d", i), bit_cnt[i], 8);
                    check($sformatf("mosi_word_%0d", i), 32'(mosi_cap[i]), 32'(exp_tx[i]));
                end
            end
            if (CS == 2'b00 || cs2 == 2'b00) inv_bad++;
            if (CS == 2'b11 && SCLK != prev_sclk) inv_bad++;
            if (cs2 == 2'b11 && sclk2 != prev_sclk2) inv_bad++;
        end
        prev_grant = OUT_GRANT;
        prev_cs    = CS;
        prev_sclk  = SCLK;
        prev_sclk2 = sclk2;
    end

    task automatic tick();
        @(negedge IN_CLK);
        #1;
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] tx, input logic [7:0] slave_ret);
        exp_tx[idx]     = tx;
        slave_word[idx] = slave_ret;
        IN_TX_DATA[idx*8 +: 8] = tx;
        exp_idx.push_back(idx);
        exp_data.push_back(slave_ret);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (OUT_GRANT == 2'b00 && n < 60) begin
            tick();
            n++;
        end
        if (OUT_GRANT == 2'b00) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((OUT_BUSY || exp_idx.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (OUT_BUSY || exp_idx.size() != 0) check("idle_timeout", 0, 1);
    endtask

    task automatic check_output_reset();
        check("rst_cs", 32'(CS), 32'(2'b11));
        check("rst_sclk", 32'(SCLK), 0);
        check("rst_mosi", 32'(MOSI), 0);
        check("rst_grant", 32'(OUT_GRANT), 0);
        check("rst_done", 32'(OUT_DONE), 0);
        check("rst_busy", 32'(OUT_BUSY), 0);
        check("rst_rx", 32'(OUT_RECEIVE_DATA), 0);
    endtask

    initial begin
        int bad;
        int n;
        int rises;
        int dn;
        int rise_c;
        int d2[3];
        logic p;
        logic half_done;

        IN_RESET   = 1'b1;
        IN_REQ     = 2'b00;
        IN_TX_DATA = 16'h0000;
        req2       = 2'b00;
        tx2        = 16'h3C00;
        slave_word[0] = 8'h00;
        slave_word[1] = 8'h00;
        slv_sr[0] = 8'h00;
        slv_sr[1] = 8'h00;
        exp_tx[0] = 8'h00;
        exp_tx[1] = 8'h00;
        repeat (3) tick();
        IN_RESET = 1'b0;
        tick();
        abort_expected = 1'b0;

        // Idle after reset, no requests.
        check_output_reset();
        bad = 0;
        repeat (100) begin
            tick();
            if (CS != 2'b11 || SCLK != 1'b0 || OUT_BUSY != 1'b0) bad++;
        end
        check("idle_100_cycles", bad, 0);

        // Single transfer from requester 0.
        apply_stimulus(0, 8'hA5, 8'h3C);
        IN_REQ = 2'b01;
        wait_grant();
        check("t2_grant", 32'(OUT_GRANT), 32'(2'b01));
        IN_REQ = 2'b00;
        IN_TX_DATA = 16'h0000;
        wait_idle();
        repeat (10) tick();
        check("rx_hold", 32'(OUT_RECEIVE_DATA), 32'(8'h3C));

        // Both requesting: alternate grants from a reset pointer.
        IN_RESET = 1'b1;
        repeat (2) tick();
        IN_RESET = 1'b0;
        tick();
        apply_stimulus(0, 8'h01, 8'hC3);
        apply_stimulus(1, 8'h80, 8'h5A);
        exp_idx.push_back(0);
        exp_data.push_back(8'hC3);
        exp_idx.push_back(1);
        exp_data.push_back(8'h5A);
        grant_log.delete();
        IN_REQ = 2'b11;
        n = 0;
        while (grant_log.size() < 4 && n < 400) begin
            tick();
            n++;
        end
        IN_REQ = 2'b00;
        if (grant_log.size() < 4) check("t3_grant_timeout", 0, 1);
        wait_idle();
        if (grant_log.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check($sformatf("t3_spacing_%0d", i), grant_log[i] - grant_log[i-1], 75);
            end
        end

        // Requester 1 arrives mid-transfer and waits for the gap to finish.
        apply_stimulus(0, 8'hF0, 8'h96);
        apply_stimulus(1, 8'h0F, 8'hE7);
        grant_log.delete();
        done_log.delete();
        IN_REQ = 2'b01;
        wait_grant();
        IN_REQ = 2'b00;
        repeat (20) tick();
        IN_REQ = 2'b10;
        n = 0;
        while (grant_log.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        IN_REQ = 2'b00;
        if (grant_log.size() < 2 || done_log.size() < 1) check("t4_grant_timeout", 0, 1);
        else begin
            check("t4_grant_after_gap", grant_log[1] - done_log[0], 3);
            check("t4_spacing", grant_log[1] - grant_log[0], 75);
        end
        wait_idle();

        // Reset mid-transfer after the third SCLK rise.
        slave_word[0] = 8'h11;
        IN_TX_DATA[7:0] = 8'h22;
        IN_REQ = 2'b01;
        wait_grant();
        IN_REQ = 2'b00;
        rises = 0;
        n = 0;
        p = SCLK;
        while (rises < 3 && n < 100) begin
            tick();
            n++;
            if (SCLK && !p) rises++;
            p = SCLK;
        end
        if (rises < 3) check("t5_rise_timeout", 0, 1);
        abort_expected = 1'b1;
        IN_RESET = 1'b1;
        tick();
        check_output_reset();
        IN_RESET = 1'b0;
        tick();
        abort_expected = 1'b0;
        repeat (100) tick();
        apply_stimulus(0, 8'h22, 8'h4B);
        IN_REQ = 2'b01;
        wait_grant();
        check("t5_fresh_grant", 32'(OUT_GRANT), 32'(2'b01));
        IN_REQ = 2'b00;
        wait_idle();

        // Fast instance: sole requester 1 served repeatedly.
        req2 = 2'b10;
        dn = 0;
        n = 0;
        bad = 0;
        rise_c = -1;
        half_done = 1'b0;
        p = sclk2;
        while (dn < 3 && n < 300) begin
            tick();
            n++;
            if (sclk2 && !p) rise_c = cyc;
            if (!sclk2 && p && rise_c >= 0 && !half_done) begin
                check("fast_sclk_half", cyc - rise_c, 2);
                half_done = 1'b1;
            end
            p = sclk2;
            if (grant2 == 2'b01) bad++;
            if (done2 != 2'b00) begin
                d2[dn] = cyc;
                check("fast_done_owner", 32'(done2), 32'(2'b10));
                check("fast_rx", 32'(rx2), 32'(8'hFF));
                dn++;
            end
        end
        req2 = 2'b00;
        if (dn < 3) check("fast_done_timeout", 0, 1);
        else begin
            check("fast_done_spacing_1", d2[1] - d2[0], 39);
            check("fast_done_spacing_2", d2[2] - d2[1], 39);
        end
        check("fast_only_req1", bad, 0);
        repeat (60) tick();

        check("scoreboard_empty", exp_idx.size(), 0);
        check("bus_invariants", inv_bad, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
